// File: rtl/ibex_irq_arbiter_if.sv
// Request/acknowledge channel between the interrupt arbiter and the core
// controller.
//   irq_req_o   : interrupt request presented to the controller
//   irq_cause_o : exc_cause_e encoding of the presented request
//   irq_ack_i   : controller accepts the presented request
// master = arbiter side, slave = controller side.
interface ibex_irq_arbiter_if;
    logic       irq_req_o;
    logic [5:0] irq_cause_o;
    logic       irq_ack_i;

    modport master (output irq_req_o, output irq_cause_o, input irq_ack_i);
    modport slave  (input irq_req_o, input irq_cause_o, output irq_ack_i);
endinterface

// File: rtl/ibex_irq_arbiter.sv
// Interrupt capture and prioritisation stage in front of the core controller.
// Registers the raw irqs_t sources, edge-detects the NMI, masks the sources,
// picks a winner by Ibex priority and presents one stable request over a
// req/ack handshake.
//
// Ports
//   clk_i, rst_i    : clock, synchronous active-high reset
//   irqs_i          : raw sources {software, timer, external, fast[14:0]}
//   irq_nm_i        : non-maskable request, rising-edge sensitive
//   mie_i           : per-source enables
//   mstatus_mie_i   : global M-mode enable
//   priv_lvl_i      : current privilege level (2'b11 = M)
//   debug_mode_i    : core is in debug mode
//   nmi_mode_i      : NMI handler active
//   mip_o           : registered pending bits
//   nmi_pending_o   : NMI latched, not yet acknowledged
//   irq_bus         : req/cause/ack channel (master side)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no request presented, waiting for an enabled source
// ST_REQ   | irq_req_o high, cause held in r_cause
// ST_ACKED | one quiet cycle after an ack so the controller can update
//          | mstatus.MIE / nmi_mode before the next evaluation
module ibex_irq_arbiter #(
    parameter bit SyncIrq = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [17:0] irqs_i,
    input  logic        irq_nm_i,
    input  logic [17:0] mie_i,
    input  logic        mstatus_mie_i,
    input  logic [1:0]  priv_lvl_i,
    input  logic        debug_mode_i,
    input  logic        nmi_mode_i,
    output logic [17:0] mip_o,
    output logic        nmi_pending_o,
    ibex_irq_arbiter_if.master irq_bus
);

    localparam logic [5:0] CAUSE_NM   = 6'h3F;
    localparam logic [5:0] CAUSE_EXT  = 6'h2B;
    localparam logic [5:0] CAUSE_SW   = 6'h23;
    localparam logic [5:0] CAUSE_TIM  = 6'h27;
    localparam logic [1:0] PRIV_LVL_M = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACKED} state_e;

    logic [17:0] w_irqs;
    logic        w_nm;

    generate
        if (SyncIrq) begin : g_sync
            logic [18:0] r_sync1;
            logic [18:0] r_sync2;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_sync1 <= '0;
                    r_sync2 <= '0;
                end else begin
                    r_sync1 <= {irq_nm_i, irqs_i};
                    r_sync2 <= r_sync1;
                end
            end
            assign {w_nm, w_irqs} = r_sync2;
        end else begin : g_nosync
            assign w_irqs = irqs_i;
            assign w_nm   = irq_nm_i;
        end
    endgenerate

    logic [17:0] r_mip;
    logic        r_nm_prev;
    logic        r_nmi_pend;
    state_e      r_state;
    logic [5:0]  r_cause;

    state_e      w_state_d;
    logic [5:0]  w_cause_d;
    logic [17:0] w_en;
    logic        w_global_en;
    logic        w_nmi_ok;
    logic        w_any;
    logic [5:0]  w_win;
    logic        w_nm_edge;
    logic        w_nm_ack;
    logic        w_req;

    assign w_en        = r_mip & mie_i;
    assign w_global_en = ((priv_lvl_i != PRIV_LVL_M) | mstatus_mie_i) & ~debug_mode_i & ~nmi_mode_i;
    assign w_nmi_ok    = r_nmi_pend & ~debug_mode_i & ~nmi_mode_i;
    assign w_any       = w_nmi_ok | (w_global_en & (|w_en));
    assign w_nm_edge   = w_nm & ~r_nm_prev;
    assign w_nm_ack    = (r_state == ST_REQ) & irq_bus.irq_ack_i & (r_cause == CAUSE_NM);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mip      <= '0;
            r_nm_prev  <= 1'b0;
            r_nmi_pend <= 1'b0;
        end else begin
            r_mip      <= w_irqs;
            r_nm_prev  <= w_nm;
            // a fresh edge coincident with the NM ack keeps the NMI pending
            r_nmi_pend <= w_nm_edge | (r_nmi_pend & ~w_nm_ack);
        end
    end

    // Winner: later assignments override earlier, so order is lowest priority first.
    always_comb begin
        w_win = 6'h00;
        if (w_en[16]) w_win = CAUSE_TIM;
        if (w_en[17]) w_win = CAUSE_SW;
        if (w_en[15]) w_win = CAUSE_EXT;
        for (int i = 0; i < 15; i++) begin
            if (w_en[i]) w_win = 6'(48 + i);
        end
        if (w_nmi_ok) w_win = CAUSE_NM;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cause <= 6'h00;
        end else begin
            r_state <= w_state_d;
            r_cause <= w_cause_d;
        end
    end

    // Next state
    always_comb begin
        w_state_d = r_state;
        w_cause_d = r_cause;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_d = ST_REQ;
                    w_cause_d = w_win;
                end
            end
            ST_REQ: begin
                if (irq_bus.irq_ack_i) begin
                    w_state_d = ST_ACKED;
                end else if (w_nmi_ok && (r_cause != CAUSE_NM)) begin
                    w_cause_d = CAUSE_NM;
                end else if (!w_any) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_ACKED: w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        w_req = (r_state == ST_REQ);
    end

    assign irq_bus.irq_req_o   = w_req;
    assign irq_bus.irq_cause_o = r_cause;
    assign mip_o               = r_mip;
    assign nmi_pending_o       = r_nmi_pend;

endmodule

// File: tb/tb_ibex_irq_arbiter.sv
module tb_ibex_irq_arbiter;

    localparam logic [17:0] B_SW  = 18'h2_0000;
    localparam logic [17:0] B_TIM = 18'h1_0000;
    localparam logic [17:0] B_EXT = 18'h0_8000;
    localparam logic [17:0] B_F3  = 18'h0_0008;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [17:0] irqs;
    logic        nm;
    logic [17:0] mie;
    logic        mstatus;
    logic [1:0]  priv;
    logic        debug;
    logic        nmi_mode;
    logic        ack;
    logic [17:0] mip0, mip1;
    logic        pend0, pend1;

    int checks = 0;
    int errors = 0;

    ibex_irq_arbiter_if u_if0 ();
    ibex_irq_arbiter_if u_if1 ();
    assign u_if0.irq_ack_i = ack;
    assign u_if1.irq_ack_i = ack;

    always #5 clk_i = ~clk_i;

    ibex_irq_arbiter #(.SyncIrq(1'b0)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .irqs_i(irqs), .irq_nm_i(nm), .mie_i(mie),
        .mstatus_mie_i(mstatus), .priv_lvl_i(priv), .debug_mode_i(debug),
        .nmi_mode_i(nmi_mode), .mip_o(mip0), .nmi_pending_o(pend0), .irq_bus(u_if0)
    );

    ibex_irq_arbiter #(.SyncIrq(1'b1)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .irqs_i(irqs), .irq_nm_i(nm), .mie_i(mie),
        .mstatus_mie_i(mstatus), .priv_lvl_i(priv), .debug_mode_i(debug),
        .nmi_mode_i(nmi_mode), .mip_o(mip1), .nmi_pending_o(pend1), .irq_bus(u_if1)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; irqs = '0; nm = 1'b0; mie = '0; mstatus = 1'b0;
        priv = 2'b11; debug = 1'b0; nmi_mode = 1'b0; ack = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_req", 32'(u_if0.irq_req_o), 32'd0);
        chk("rst_cause", 32'(u_if0.irq_cause_o), 32'h00);
        chk("rst_mip", 32'(mip0), 32'h0);
        chk("rst_pend", 32'(pend0), 32'd0);

        // timer, 2-cycle latency, held without ack
        mie = B_TIM; mstatus = 1'b1; priv = 2'b11; irqs = B_TIM;
        tick();
        chk("tim_mip", 32'(mip0), 32'(B_TIM));
        chk("tim_req_c1", 32'(u_if0.irq_req_o), 32'd0);
        tick();
        chk("tim_req_c2", 32'(u_if0.irq_req_o), 32'd1);
        chk("tim_cause", 32'(u_if0.irq_cause_o), 32'h27);
        tick();
        chk("tim_hold", 32'(u_if0.irq_req_o), 32'd1);
        chk("tim_hold_cause", 32'(u_if0.irq_cause_o), 32'h27);
        irqs = '0; ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("tim_acked_req", 32'(u_if0.irq_req_o), 32'd0);
        tick(); tick();
        chk("tim_idle_req", 32'(u_if0.irq_req_o), 32'd0);

        // fast[3] beats external; cause held after fast[3] drops
        mie = B_F3 | B_EXT; irqs = B_F3 | B_EXT;
        tick(); tick();
        chk("f3_req", 32'(u_if0.irq_req_o), 32'd1);
        chk("f3_cause", 32'(u_if0.irq_cause_o), 32'h33);
        irqs = B_EXT;
        tick(); tick();
        chk("f3_held_req", 32'(u_if0.irq_req_o), 32'd1);
        chk("f3_held_cause", 32'(u_if0.irq_cause_o), 32'h33);
        irqs = '0;
        tick(); tick();
        chk("wd_req", 32'(u_if0.irq_req_o), 32'd0);
        chk("wd_cause_last", 32'(u_if0.irq_cause_o), 32'h33);

        // NMI preempts external before ack
        irqs = B_EXT;
        tick(); tick();
        chk("ext_cause", 32'(u_if0.irq_cause_o), 32'h2B);
        nm = 1'b1;
        tick();
        nm = 1'b0;
        chk("nm_pend_set", 32'(pend0), 32'd1);
        tick();
        chk("nm_preempt_req", 32'(u_if0.irq_req_o), 32'd1);
        chk("nm_preempt_cause", 32'(u_if0.irq_cause_o), 32'h3F);
        ack = 1'b1; mstatus = 1'b0;
        tick();
        ack = 1'b0;
        chk("nm_ack_pend", 32'(pend0), 32'd0);
        chk("nm_acked_req", 32'(u_if0.irq_req_o), 32'd0);
        tick(); tick();
        chk("nm_masked_req", 32'(u_if0.irq_req_o), 32'd0);
        chk("nm_mip_ext", 32'(mip0), 32'(B_EXT));

        // new NMI edge coincident with NM ack keeps pending
        nm = 1'b1;
        tick();
        nm = 1'b0;
        tick();
        chk("nm2_req", 32'(u_if0.irq_req_o), 32'd1);
        chk("nm2_cause", 32'(u_if0.irq_cause_o), 32'h3F);
        ack = 1'b1; nm = 1'b1;
        tick();
        ack = 1'b0; nm = 1'b0; nmi_mode = 1'b1;
        chk("nm2_pend_kept", 32'(pend0), 32'd1);
        chk("nm2_acked_req", 32'(u_if0.irq_req_o), 32'd0);
        tick(); tick();
        chk("nm2_nmimode_req", 32'(u_if0.irq_req_o), 32'd0);
        nmi_mode = 1'b0;
        tick();
        chk("nm2_rearm_req", 32'(u_if0.irq_req_o), 32'd1);
        chk("nm2_rearm_cause", 32'(u_if0.irq_cause_o), 32'h3F);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("nm2_final_pend", 32'(pend0), 32'd0);

        // U-mode ignores mstatus.MIE; debug mode withdraws
        irqs = B_SW; mie = B_SW; priv = 2'b00; mstatus = 1'b0;
        tick(); tick();
        chk("sw_req", 32'(u_if0.irq_req_o), 32'd1);
        chk("sw_cause", 32'(u_if0.irq_cause_o), 32'h23);
        debug = 1'b1;
        tick();
        chk("dbg_withdraw", 32'(u_if0.irq_req_o), 32'd0);
        tick();
        chk("dbg_stay_idle", 32'(u_if0.irq_req_o), 32'd0);
        irqs = '0;
        tick(); tick();
        debug = 1'b0;
        tick();

        // synchroniser latency and reset in REQ
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        mie = B_TIM; priv = 2'b11; mstatus = 1'b1; irqs = B_TIM;
        tick(); tick();
        chk("sync0_req_c2", 32'(u_if0.irq_req_o), 32'd1);
        chk("sync1_req_c2", 32'(u_if1.irq_req_o), 32'd0);
        tick();
        chk("sync1_req_c3", 32'(u_if1.irq_req_o), 32'd0);
        tick();
        chk("sync1_req_c4", 32'(u_if1.irq_req_o), 32'd1);
        chk("sync1_cause", 32'(u_if1.irq_cause_o), 32'h27);
        nm = 1'b1;
        tick();
        chk("pre_rst_pend", 32'(pend0), 32'd1);
        rst_i = 1'b1;
        tick();
        chk("rst_mid_req", 32'(u_if0.irq_req_o), 32'd0);
        chk("rst_mid_cause", 32'(u_if0.irq_cause_o), 32'h00);
        chk("rst_mid_mip", 32'(mip0), 32'h0);
        chk("rst_mid_pend", 32'(pend0), 32'd0);
        chk("rst_mid_req1", 32'(u_if1.irq_req_o), 32'd0);
        rst_i = 1'b0; nm = 1'b0; irqs = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_irq_arbiter.md
Name: ibex_irq_arbiter

Overview:
- Interrupt capture and prioritisation stage that feeds the controller.
- Registers the raw irqs_t sources and edge-detects the NMI.
- Masks the sources with mie and the global enable, picks the winner by Ibex priority, and presents one stable request with its exc_cause_e over a req/ack handshake.
- Supplies mip to the CSR file.

Parameters:
- SyncIrq, 1'b0: when 1, inserts a 2-flop synchroniser on every irq input, including irq_nm_i, ahead of the capture register.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- irqs_i  in  18 (irqs_t)  raw level-sensitive software/timer/external/fast[14:0] requests
- irq_nm_i  in  1  non-maskable interrupt request; rising-edge sensitive
- mie_i  in  18 (irqs_t)  per-source enables from the CSR file
- mstatus_mie_i  in  1  global M-mode interrupt enable
- priv_lvl_i  in  2 (priv_lvl_e)  current privilege level
- debug_mode_i  in  1  core is in debug mode
- nmi_mode_i  in  1  NMI handler active
- irq_ack_i  in  1  controller accepts the presented interrupt
- mip_o  out  18 (irqs_t)  registered pending bits
- irq_req_o  out  1  interrupt request to the controller
- irq_cause_o  out  6 (exc_cause_e)  cause of the presented request
- nmi_pending_o  out  1  NMI latched and not yet acknowledged

Behaviour:
- Reset: all flops 0, including synchroniser stages, mip_q, nm_prev_q and nmi_pend_q. FSM goes to IDLE. All outputs are 0, so irq_cause_o = EXC_CAUSE_INSN_ADDR_MISA encoding.
- Capture: mip_q <= irqs_i (after the synchroniser if SyncIrq). mip_o = mip_q.
- NMI latch: nm_prev_q tracks irq_nm_i (synchronised when SyncIrq). A rising edge (irq_nm_i & ~nm_prev_q) sets nmi_pend_q.
  - nmi_pend_q clears when irq_ack_i is taken with cause EXC_CAUSE_IRQ_NM.
  - A new edge in the same cycle as that ack wins: pending stays 1.
  - Further edges while already pending merge; there is no counting.
  - nmi_pending_o = nmi_pend_q.
- Enables:
  - en = mip_q & mie_i.
  - global_en = (priv_lvl_i != PRIV_LVL_M | mstatus_mie_i) & ~debug_mode_i & ~nmi_mode_i.
  - nmi_ok = nmi_pend_q & ~debug_mode_i & ~nmi_mode_i.
- Priority, highest first:
  - NMI (cause {1,31})
  - fast[14] down to fast[0] (cause {1, 16+n})
  - external ({1,11})
  - software ({1,3})
  - timer ({1,7})
- any = nmi_ok | (global_en & |en). win_cause is the combinational winner.
- FSM (registered state; irq_req_o = state==REQ):
  - IDLE: if any, latch cause_q <= win_cause and go to REQ.
  - REQ: irq_cause_o = cause_q; it is stable except for the rules below.
    - If irq_ack_i: go to ACKED. The ack applies to cause_q as seen that cycle.
    - Else if nmi_ok and cause_q != NM: cause_q <= NM (NMI preempts before ack); stay in REQ.
    - Else if ~any: withdraw and return to IDLE. irq_req_o drops the next cycle; no ack is required.
    - Else: hold. A newly raised higher-priority maskable source does not replace cause_q.
  - ACKED: one cycle with irq_req_o = 0, giving the controller time to clear mstatus.MIE and set nmi_mode. Then go to IDLE.
  - irq_ack_i outside REQ is ignored.
- irq_cause_o = cause_q in every state (holds its last value); 0 after reset.
- Latency, SyncIrq=0: a source high before edge N is in mip_q after N; irq_req_o = 1 after edge N+1, i.e. 2 cycles. SyncIrq=1 adds 2 cycles.
- Reset mid-operation: synchronous reset in REQ drops irq_req_o and clears nmi_pend_q on that edge.

Test Plan:
- irqs_i.irq_timer=1, mie timer=1, mstatus_mie_i=1, priv=M; no ack → irq_req_o rises exactly 2 cycles later; cause 6'h27; held while ack=0; mip_o shows bit set 1 cycle after input.
- irq_fast[3] and irq_external high together, both enabled → cause 6'h33. Drop fast[3] before ack → cause stays 6'h33 until the ack or until all sources drop (withdraw → IDLE).
- In REQ with cause 6'h2B, pulse irq_nm_i one cycle → next cycle cause 6'h3F; ack → nmi_pending_o 0, one ACKED cycle with req 0. The external source is then still pending, but req stays 0 if mstatus_mie_i was cleared.
- irq_nm_i rising edge in the same cycle as the ack of NM → nmi_pending_o stays 1; req reasserts after ACKED once nmi_mode_i=0.
- priv=U, mstatus_mie_i=0, software enabled → request with cause 6'h23. debug_mode_i=1 → no request, and an in-flight REQ withdraws within 1 cycle.
- SyncIrq=1: timer request latency is 4 cycles. rst_i asserted during REQ → next cycle irq_req_o=0, irq_cause_o=0, mip_o=0.
